// File: rtl/evenodd_pkg.sv
// evenodd_pkg
//   Shared types and helpers for the even/odd streaming classifier.
//   - EVENODD_DEF_W / EVENODD_DEF_CNT_W : default data and counter widths
//   - evenodd_class_t : per-word classification (even, odd and, when the
//                       EVENODD_PARITY_EN macro is defined, par)
//   - classify()      : builds the classification from a zero-extended word
//                       (words up to 64 bits)
//   - sat_inc()       : saturating increment (counters up to 32 bits)
package evenodd_pkg;

    localparam int unsigned EVENODD_DEF_W     = 16;
    localparam int unsigned EVENODD_DEF_CNT_W = 8;

    typedef struct packed {
        logic even;
        logic odd;
`ifdef EVENODD_PARITY_EN
        logic par;
`endif
    } evenodd_class_t;

    function automatic evenodd_class_t classify(input logic [63:0] word);
        evenodd_class_t c;
        c.even = ~word[0];
        c.odd  = word[0];
`ifdef EVENODD_PARITY_EN
        // Zero extension does not change the XOR reduction.
        c.par  = ^word;
`endif
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/evenodd_sat_cnt.sv
// evenodd_sat_cnt
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clr      : synchronous clear; an inc in the same cycle counts after it
//     inc      : increment request
//     cnt      : current count (stops at 2^CNT_W-1)
//     sat      : count is at its maximum
module evenodd_sat_cnt
    import evenodd_pkg::*;
#(
    parameter int unsigned CNT_W = EVENODD_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [31:0] inc_val;

    always_comb inc_val = sat_inc(32'(cnt), 32'(MAX));

    // Saturated exactly when the increment would leave the value unchanged.
    // The flag is sticky because the count cannot leave MAX except via clr/rst.
    always_comb sat = (inc_val == 32'(cnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            cnt <= inc_val[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/evenodd_stream.sv
// evenodd_stream
//   Streaming even/odd classifier with a one-deep registered output stage and
//   saturating per-class word counters. Full valid/ready backpressure,
//   one word per cycle when the consumer keeps out_ready high. W <= 64.
//   Optional feature: define EVENODD_PARITY_EN to add out_par and par_cnt.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     clr                 : synchronous clear of counters and cnt_sat
//     in_valid/in_ready   : input handshake, in_data is the W-bit word
//     out_valid/out_ready : output handshake
//     out_even, out_odd   : registered LSB classification
//     out_par             : (EVENODD_PARITY_EN) registered XOR of the word
//     even_cnt, odd_cnt   : saturating counts of accepted words per class
//     par_cnt             : (EVENODD_PARITY_EN) count of odd-parity words
//     cnt_sat             : some counter has reached its maximum
module evenodd_stream
    import evenodd_pkg::*;
#(
    parameter int unsigned W     = EVENODD_DEF_W,
    parameter int unsigned CNT_W = EVENODD_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_even,
    output logic             out_odd,
`ifdef EVENODD_PARITY_EN
    output logic             out_par,
    output logic [CNT_W-1:0] par_cnt,
`endif
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt,
    output logic             cnt_sat
);

    evenodd_class_t cls_d;
    evenodd_class_t cls_q;
    logic           accept;
    logic           even_sat;
    logic           odd_sat;

    // The stage can take a word when empty or when it is being drained now.
    always_comb in_ready = !out_valid || out_ready;
    always_comb accept   = in_valid && in_ready;
    always_comb cls_d    = classify(64'(in_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            cls_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            cls_q     <= cls_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb out_even = cls_q.even;
    always_comb out_odd  = cls_q.odd;

    evenodd_sat_cnt #(.CNT_W(CNT_W)) u_even_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (accept && cls_d.even),
        .cnt (even_cnt),
        .sat (even_sat)
    );

    evenodd_sat_cnt #(.CNT_W(CNT_W)) u_odd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (accept && cls_d.odd),
        .cnt (odd_cnt),
        .sat (odd_sat)
    );

`ifdef EVENODD_PARITY_EN
    logic par_sat;

    always_comb out_par = cls_q.par;

    evenodd_sat_cnt #(.CNT_W(CNT_W)) u_par_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (accept && cls_d.par),
        .cnt (par_cnt),
        .sat (par_sat)
    );

    always_comb cnt_sat = even_sat | odd_sat | par_sat;
`else
    always_comb cnt_sat = even_sat | odd_sat;
`endif

endmodule

// File: tb/tb_evenodd_stream.sv
`timescale 1ns/1ps
module tb_evenodd_stream;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 8;
    localparam int          MAXC  = 255;
`ifdef EVENODD_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CNT_W = 8)
    logic             rst, clr, in_valid, in_ready, out_valid, out_ready;
    logic             out_even, out_odd, cnt_sat;
    logic [W-1:0]     in_data;
    logic [CNT_W-1:0] even_cnt, odd_cnt;
`ifdef EVENODD_PARITY_EN
    logic             out_par;
    logic [CNT_W-1:0] par_cnt;
`endif

    // Narrow-counter instance (CNT_W = 2) for saturation
    logic             s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic             s_out_even, s_out_odd, s_cnt_sat;
    logic [W-1:0]     s_in_data;
    logic [1:0]       s_even_cnt, s_odd_cnt;
`ifdef EVENODD_PARITY_EN
    logic             s_out_par;
    logic [1:0]       s_par_cnt;
`endif

    evenodd_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_even(out_even), .out_odd(out_odd),
`ifdef EVENODD_PARITY_EN
        .out_par(out_par), .par_cnt(par_cnt),
`endif
        .even_cnt(even_cnt), .odd_cnt(odd_cnt), .cnt_sat(cnt_sat)
    );

    evenodd_stream #(.W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clr(s_clr),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_even(s_out_even), .out_odd(s_out_odd),
`ifdef EVENODD_PARITY_EN
        .out_par(s_out_par), .par_cnt(s_par_cnt),
`endif
        .even_cnt(s_even_cnt), .odd_cnt(s_odd_cnt), .cnt_sat(s_cnt_sat)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the main instance: what the consumer should see.
    bit m_valid, m_even, m_odd, m_par, m_sat;
    int m_ecnt, m_ocnt, m_pcnt;

    task automatic model_reset();
        m_valid = 0; m_even = 0; m_odd = 0; m_par = 0; m_sat = 0;
        m_ecnt = 0; m_ocnt = 0; m_pcnt = 0;
    endtask

    function automatic int sat_add(input int v);
        return (v + 1 > MAXC) ? MAXC : v + 1;
    endfunction

    // Applies one clock edge of the rules to the model using current inputs.
    task automatic model_edge();
        bit acc;
        acc = in_valid && (!m_valid || out_ready);
        if (clr) begin
            m_ecnt = 0; m_ocnt = 0; m_pcnt = 0;
        end
        if (acc) begin
            m_valid = 1;
            m_odd   = (in_data % 2) == 1;
            m_even  = !m_odd;
            m_par   = ($countones(in_data) % 2) == 1;
            if (m_odd) m_ocnt = sat_add(m_ocnt);
            else       m_ecnt = sat_add(m_ecnt);
            if (m_par) m_pcnt = sat_add(m_pcnt);
        end else if (out_ready) begin
            m_valid = 0;
        end
        m_sat = (m_ecnt == MAXC) || (m_ocnt == MAXC) || (PAR_EN && m_pcnt == MAXC);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy, input bit c);
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = rdy; clr = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1; in_valid = 0; out_ready = 0; clr = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; clr = 0; in_valid = 0; in_data = '0; out_ready = 0;
        s_clr = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0;
        model_reset();
        #2;
        checks++;
        if ({out_valid, out_even, out_odd, cnt_sat, in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: got v/e/o/sat/rdy=%b expected 00001",
                     {out_valid, out_even, out_odd, cnt_sat, in_ready});
        end
        checks++;
        if (even_cnt !== '0 || odd_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counts: got even=%0d odd=%0d expected 0 0", even_cnt, odd_cnt);
        end
`ifdef EVENODD_PARITY_EN
        checks++;
        if (out_par !== 1'b0 || par_cnt !== '0) begin
            errors++;
            $display("FAIL reset_par: got out_par=%b par_cnt=%0d expected 0 0", out_par, par_cnt);
        end
`endif
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive(1, W'(i), 1, 0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_even, out_odd} !== {1'b1, (i % 2) == 0, (i % 2) == 1}) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got v/e/o=%b%b%b expected 1%b%b", i,
                         out_valid, out_even, out_odd, (i % 2) == 0, (i % 2) == 1);
            end
        end
        checks++;
        if (even_cnt !== 8'd8 || odd_cnt !== 8'd8 || cnt_sat !== 1'b0) begin
            errors++;
            $display("FAIL b2b_counts: got even=%0d odd=%0d sat=%b expected 8 8 0",
                     even_cnt, odd_cnt, cnt_sat);
        end
        drive(0, '0, 1, 0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_odd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b odd=%b expected 0 1 (held)", out_valid, out_odd);
        end
    endtask

    task automatic test_backpressure();
        int e_before;
        drive(1, 16'h0003, 1, 0);
        tick();
        e_before = m_ecnt;
        for (int k = 0; k < 4; k++) begin
            drive(1, 16'h0004, 0, 0);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected 0", k, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_even, out_odd} !== 3'b101 || even_cnt !== CNT_W'(e_before)) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v/e/o=%b%b%b even=%0d expected 101 even=%0d",
                         k, out_valid, out_even, out_odd, even_cnt, e_before);
            end
        end
        drive(1, 16'h0004, 1, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_even, out_odd} !== 3'b110 || even_cnt !== CNT_W'(e_before + 1)) begin
            errors++;
            $display("FAIL bp_release: got v/e/o=%b%b%b even=%0d expected 110 even=%0d",
                     out_valid, out_even, out_odd, even_cnt, e_before + 1);
        end
        drive(0, '0, 1, 0);
        tick();
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            s_in_valid = 1; s_in_data = W'(2 * k); s_out_ready = 1; s_clr = 0;
            @(posedge clk);
            #1;
            checks++;
            if (s_even_cnt !== 2'((k > 3) ? 3 : k) || s_cnt_sat !== (k >= 3) || s_odd_cnt !== 2'd0) begin
                errors++;
                $display("FAIL sat_word[%0d]: got even=%0d odd=%0d sat=%b expected %0d 0 %b",
                         k, s_even_cnt, s_odd_cnt, s_cnt_sat, (k > 3) ? 3 : k, k >= 3);
            end
        end
        @(negedge clk);
        s_in_valid = 0; s_clr = 1;
        @(posedge clk);
        #1;
        checks++;
        if (s_even_cnt !== 2'd0 || s_cnt_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got even=%0d sat=%b expected 0 0", s_even_cnt, s_cnt_sat);
        end
        @(negedge clk);
        s_clr = 0;
    endtask

    task automatic test_clr();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin drive(1, W'(2 * i + 2), 1, 0); tick(); end
        for (int i = 0; i < 7; i++) begin drive(1, W'(2 * i + 1), 1, 0); tick(); end
        checks++;
        if (even_cnt !== 8'd5 || odd_cnt !== 8'd7) begin
            errors++;
            $display("FAIL clr_setup: got even=%0d odd=%0d expected 5 7", even_cnt, odd_cnt);
        end
        drive(1, 16'h0005, 1, 1);
        tick();
        checks++;
        if (even_cnt !== 8'd0 || odd_cnt !== 8'd1 || cnt_sat !== 1'b0 || out_odd !== 1'b1) begin
            errors++;
            $display("FAIL clr_accept: got even=%0d odd=%0d sat=%b out_odd=%b expected 0 1 0 1",
                     even_cnt, odd_cnt, cnt_sat, out_odd);
        end
        // clr under backpressure leaves the held result alone
        drive(0, '0, 0, 1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_odd !== 1'b1 || odd_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_hold: got valid=%b odd=%b odd_cnt=%0d expected 1 1 0",
                     out_valid, out_odd, odd_cnt);
        end
    endtask

    task automatic test_rst_mid();
        drive(1, 16'h0009, 0, 0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: got valid=%b ready=%b expected 1 0", out_valid, in_ready);
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_even, out_odd, cnt_sat, in_ready} !== 5'b00001 ||
            even_cnt !== '0 || odd_cnt !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got v/e/o/sat/rdy=%b even=%0d odd=%0d expected 00001 0 0",
                     {out_valid, out_even, out_odd, cnt_sat, in_ready}, even_cnt, odd_cnt);
        end
        @(negedge clk);
        rst = 0;
        in_valid = 0;
    endtask

    task automatic test_parity();
`ifdef EVENODD_PARITY_EN
        logic [W-1:0] words [3];
        bit           exp_par [3];
        words[0] = 16'h0007; words[1] = 16'h0003; words[2] = 16'h8000;
        exp_par[0] = 1; exp_par[1] = 0; exp_par[2] = 1;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, words[i], 1, 0);
            tick();
            checks++;
            if (out_par !== exp_par[i]) begin
                errors++;
                $display("FAIL par_word[%0d]: got out_par=%b expected %b", i, out_par, exp_par[i]);
            end
        end
        checks++;
        if (par_cnt !== 8'd2 || odd_cnt !== 8'd2 || even_cnt !== 8'd1) begin
            errors++;
            $display("FAIL par_counts: got par=%0d odd=%0d even=%0d expected 2 2 1",
                     par_cnt, odd_cnt, even_cnt);
        end
        drive(0, '0, 1, 0);
        tick();
`endif
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 700; n++) begin
            drive(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 300) == 0);
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", n, in_ready, !m_valid || out_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_even, out_odd, cnt_sat} !== {m_valid, m_even, m_odd, m_sat} ||
                even_cnt !== CNT_W'(m_ecnt) || odd_cnt !== CNT_W'(m_ocnt)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v/e/o/sat=%b even=%0d odd=%0d expected %b%b%b%b %0d %0d",
                         n, {out_valid, out_even, out_odd, cnt_sat}, even_cnt, odd_cnt,
                         m_valid, m_even, m_odd, m_sat, m_ecnt, m_ocnt);
            end
`ifdef EVENODD_PARITY_EN
            checks++;
            if (out_par !== m_par || par_cnt !== CNT_W'(m_pcnt)) begin
                errors++;
                $display("FAIL rand_par[%0d]: got out_par=%b par_cnt=%0d expected %b %0d",
                         n, out_par, par_cnt, m_par, m_pcnt);
            end
`endif
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_clr();
        test_rst_mid();
        test_parity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/evenodd_stream.md
# evenodd_stream

Parametrised, streaming successor to the combinational even/odd checker. Accepts a valid/ready stream of W-bit words, registers each word's even/odd classification into a one-deep output stage, and keeps running saturating counts of even and odd words. Sits between a data producer and a statistics/monitor consumer; supports full backpressure.

## Interface
- W, 16, data word width (≥1)
- CNT_W, 8, width of each counter (≥2)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous counter clear, single-cycle pulse
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  W  input word
- out_valid  out  1  classification result valid
- out_ready  in  1  consumer accepts result
- out_even  out  1  1 when registered word LSB = 0
- out_odd  out  1  1 when registered word LSB = 1; always ~out_even while out_valid
- even_cnt  out  CNT_W  count of accepted even words
- odd_cnt  out  CNT_W  count of accepted odd words
- cnt_sat  out  1  sticky: either counter has reached 2^CNT_W−1

## Operation
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational from out_valid/out_ready; no path from in_valid).
- On accept: out_even/out_odd loaded from in_data[0]; out_valid set; matching counter +1.
- Output held stable while out_valid && !out_ready. out_valid clears on out_ready with no new accept.
- Simultaneous drain and accept: out_valid stays 1, new result replaces old same edge (full throughput, 1 word/cycle).
- Counters saturate at 2^CNT_W−1; further words of that class do not wrap. cnt_sat sets on the edge where either counter reaches max, stays set until clr or rst.
- clr: both counters and cnt_sat → 0. clr with a simultaneous accept: clear applied first, then accepted word counted (that counter = 1, other = 0). clr does not affect out_valid/out_even/out_odd.
- When out_valid = 0, out_even/out_odd hold last values (don't-care to consumer).

## Timing
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_even=0, out_odd=0, even_cnt=0, odd_cnt=0, cnt_sat=0; in_ready=1 immediately.
- Latency: accept on edge N → out_valid and result visible after edge N; counters updated same edge.
- rst mid-stream: in-flight result dropped, no counts retained.
- Counter values reflect every accepted word, independent of output drain.

## Configuration
- EVENODD_PARITY_EN defined: adds port out_par (out, 1) = XOR reduction of the registered word (1 = odd number of set bits), registered alongside out_even/out_odd, reset 0, held under backpressure; adds par_cnt (out, CNT_W) counting accepted words with odd parity, same saturation/clr rules, included in cnt_sat.
- Undefined: no out_par/par_cnt ports, no XOR logic; behaviour otherwise identical.

## Structure
- Package evenodd_pkg: classification struct (even, odd, par bits), default W/CNT_W constants, saturating-increment function.
- Sub-module evenodd_sat_cnt: CNT_W saturating counter with clr, inc, sat flag; instantiated per counter (two, three with EVENODD_PARITY_EN).
- Top holds handshake register and classification logic.

## Test plan
- Reset then words 0x0000..0x000F back-to-back, out_ready=1 → results alternate even/odd one cycle after each, even_cnt=8, odd_cnt=8, cnt_sat=0.
- Send 0x0003 with out_ready=0 for 4 cycles, then 0x0004 offered → in_ready=0, out_odd=1 held, 0x0004 accepted only on the out_ready=1 cycle; even_cnt increments then.
- CNT_W=2, five even words → even_cnt=3 after third word and stays 3, cnt_sat=1 after third word.
- clr asserted in same cycle as accept of 0x0005 with counts (5,7) → even_cnt=0, odd_cnt=1, cnt_sat=0.
- rst asserted while out_valid=1 held under backpressure → all outputs 0, in_ready=1 in the same cycle.
- With EVENODD_PARITY_EN, words 0x0007, 0x0003, 0x8000 → out_par=1,0,1; par_cnt=2; odd_cnt=2, even_cnt=1.
